btn_conditioner: RTL
====================

Name: btn_conditioner

Overview:
- Front-end for the four-button lab top level. Takes raw BTNR/BTNU/BTND/BTNL pad levels and produces synchronized, debounced levels plus single-cycle press pulses for the downstream control FSM (LED / 7-seg logic).
- Also provides a one-hot-free priority event code, so the consumer can handle at most one command per cycle.

Parameters:
- TICK_DIV, 256, clk cycles per debounce sample tick (256 = 2.56 us at a 100 MHz sim clock; hardware build overrides it).
- DEB_DEPTH, 4, number of consecutive identical samples needed to change the debounced level (range 2..16).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- btn_raw  in  4  raw pad levels; index 0=R, 1=U, 2=D, 3=L; asynchronous to clk.
- btn_level  out  4  debounced level per button.
- btn_pulse  out  4  one-cycle pulse per debounced rising edge (press).
- evt_valid  out  1  high in any cycle where btn_pulse != 0.
- evt_code  out  2  index of highest-priority pulsing button; priority R(0) > U(1) > D(2) > L(3).

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- Reset state (cycle after rst sampled high) — all of the following are 0:
  - sync flops, tick counter, sample shift registers;
  - btn_level, btn_pulse, evt_valid, evt_code.
- Synchronizer: two-flop chain per bit, sync = btn_raw delayed 2 cycles.
- Tick generator:
  - tick_cnt counts 0..TICK_DIV-1 and wraps to 0.
  - tick is high for exactly one cycle when tick_cnt == TICK_DIV-1.
  - One counter is shared by all channels.
- Per-channel shift register (DEB_DEPTH bits):
  - On tick, shift sync in at LSB. No change between ticks.
- Debounced level update, evaluated the cycle after the shift:
  - all ones -> btn_level=1;
  - all zeros -> btn_level=0;
  - otherwise hold.
- Pulse:
  - btn_pulse[i] = btn_level[i] & ~btn_level_d[i], registered.
  - Exactly one cycle per press; none on release.
  - A held button never re-pulses.
- Latency from btn_raw rising (stable) to btn_pulse:
  - min = 2 + (DEB_DEPTH-1)*TICK_DIV + 2 cycles;
  - max = 2 + DEB_DEPTH*TICK_DIV + 2 cycles.
  - The bench checks within this window.
- Glitch rejection: any excursion shorter than (DEB_DEPTH-1)*TICK_DIV cycles never changes btn_level.
- Simultaneous presses:
  - All corresponding btn_pulse bits assert in the same cycle.
  - evt_valid=1 and evt_code = lowest asserted index.
  - Lower-priority presses are visible only on btn_pulse; they are not queued.
- evt_valid/evt_code are registered together with btn_pulse (same cycle). evt_code holds 0 when evt_valid=0.
- Reset mid-operation:
  - Everything clears immediately; any pulse in flight is dropped.
  - A button still held after reset release is treated as a new press and pulses once after the normal latency.
- Tick counter width: clog2(TICK_DIV). No overflow beyond the wrap; tick_cnt never exceeds TICK_DIV-1.

Decomposition:
- Shared package btn_pkg:
  - index constants BTN_R=0, BTN_U=1, BTN_D=2, BTN_L=3;
  - NUM_BTN=4;
  - evt_code encoding (same values as the indices).
- Natural sub-module: btn_debounce_ch, one channel covering:
  - 2-flop sync, shift register, level, pulse;
  - inputs clk, rst, tick, raw; outputs level, pulse.
- Top level instantiates btn_debounce_ch four times and owns the tick counter and the priority encoder.

Test Plan:
- Reset: rst=1 for 10 cycles with btn_raw=4'b1111 -> all outputs 0 throughout; after release, with btn_raw held, exactly one pulse per bit within [2+3*256+2, 2+4*256+2] cycles.
- Single press: btn_raw[0] 0->1, held 5000 cycles, then 0 -> btn_pulse=4'b0001 for one cycle with evt_valid=1, evt_code=0; btn_level[0]=1 until ~1024 cycles after release; no pulse on release.
- Bounce: btn_raw[1] toggles every 100 cycles for 600 cycles, then settles to 1 -> btn_level[1] and btn_pulse[1] stay 0 during bouncing; exactly one pulse after settling.
- Short glitch: btn_raw[2]=1 for 500 cycles (<768) -> btn_level[2] never asserts, no pulse.
- Simultaneous: btn_raw=4'b1010 in the same cycle -> btn_pulse=4'b1010 in one cycle, evt_valid=1, evt_code=1.
- Repeat presses: btn_raw[0] pressed 7 times (5000 cycles on / 5000 off), then btn_raw[1] twice -> exactly 7 pulses on bit 0 and 2 on bit 1; no other btn_pulse activity.

Source files
------------

// File: rtl/btn_pkg.sv
// btn_pkg: shared button indices, event code encoding and priority helper
package btn_pkg;
  localparam int NUM_BTN = 4;
  localparam int BTN_R = 0;
  localparam int BTN_U = 1;
  localparam int BTN_D = 2;
  localparam int BTN_L = 3;
  typedef enum logic [1:0] {
    EVT_R = 2'(BTN_R),
    EVT_U = 2'(BTN_U),
    EVT_D = 2'(BTN_D),
    EVT_L = 2'(BTN_L)
  } evt_code_e;
  // lowest set index wins; an empty vector encodes as EVT_R (0)
  function automatic evt_code_e prio_code(input logic [NUM_BTN-1:0] p);
    evt_code_e c;
    c = EVT_R;
    for (int i = NUM_BTN - 1; i >= 0; i--) if (p[i]) c = evt_code_e'(i[1:0]);
    return c;
  endfunction
endpackage

// File: rtl/btn_conditioner_if.sv
// btn_conditioner_if: raw button inputs and conditioned outputs of the button front-end
interface btn_conditioner_if;
  import btn_pkg::*;
  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_pulse;
  logic               evt_valid;
  evt_code_e          evt_code;
  modport master (output btn_raw, input btn_level, btn_pulse, evt_valid, evt_code);
  modport slave  (input btn_raw, output btn_level, btn_pulse, evt_valid, evt_code);
endinterface

// File: rtl/btn_debounce_ch.sv
// btn_debounce_ch: one button channel - 2-flop sync, tick-sampled shift register, level and press pulse
module btn_debounce_ch #(
  parameter int DEB_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_tick,
  input  logic i_raw,
  output logic o_level,
  output logic o_pulse
);
  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_level_d;
  logic [DEB_DEPTH-1:0] r_shift;
  // level follows the shift register only once it is unanimous, so it lags the last shift by one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_shift   <= '0;
      o_level   <= 1'b0;
      r_level_d <= 1'b0;
      o_pulse   <= 1'b0;
    end else begin
      r_sync1   <= i_raw;
      r_sync2   <= r_sync1;
      if (i_tick) r_shift <= {r_shift[DEB_DEPTH-2:0], r_sync2};
      o_level   <= &r_shift ? 1'b1 : ~|r_shift ? 1'b0 : o_level;
      r_level_d <= o_level;
      o_pulse   <= o_level & ~r_level_d;
    end
  end
endmodule

// File: rtl/btn_conditioner.sv
// btn_conditioner: four-button debounce front-end with shared sample tick and priority event code
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int TICK_DIV  = 256,
  parameter int DEB_DEPTH = 4
) (
  input logic               clk,
  input logic               rst,
  btn_conditioner_if.slave  bus
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  logic [CW-1:0]      r_tick_cnt;
  logic               w_tick;
  logic [NUM_BTN-1:0] w_level;
  logic [NUM_BTN-1:0] w_pulse;
  assign w_tick = r_tick_cnt == CW'(TICK_DIV - 1);
  // shared sample-tick divider, wraps at TICK_DIV-1
  always_ff @(posedge clk) begin
    r_tick_cnt <= (rst || w_tick) ? '0 : r_tick_cnt + 1'b1;
  end
  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    btn_debounce_ch #(.DEB_DEPTH(DEB_DEPTH)) u_ch (
      .clk     (clk),
      .rst     (rst),
      .i_tick  (w_tick),
      .i_raw   (bus.btn_raw[g]),
      .o_level (w_level[g]),
      .o_pulse (w_pulse[g])
    );
  end
  // event decode is taken straight from the registered pulses so it lands in the same cycle
  assign bus.btn_level = w_level;
  assign bus.btn_pulse = w_pulse;
  assign bus.evt_valid = |w_pulse;
  assign bus.evt_code  = prio_code(w_pulse);
endmodule
